// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one N-bit 4-op ALU between two requesters
module alu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       r_state;
    logic         r_ptr;
    logic         r_id;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [1:0]   r_op;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_result;
    logic         w_idle;
    logic         w_g0;
    logic         w_g1;
    logic [N-1:0] w_alu;
    // rst_n gates the grants so ready stays low while reset is held
    assign w_idle = rst_n && (r_state == IDLE);
    assign w_g0 = w_idle && req0_valid && (!req1_valid || !r_ptr);
    assign w_g1 = w_idle && req1_valid && (!req0_valid || r_ptr);
    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy = (r_state != IDLE);
    always_comb begin
        w_alu = (r_op == 2'b00) ? r_a + r_b :
                (r_op == 2'b01) ? r_a | r_b :
                (r_op == 2'b10) ? r_a - r_b : r_a ^ r_b;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr <= 1'b0;
            r_id <= 1'b0;
            r_a <= '0;
            r_b <= '0;
            r_op <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_id <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_g0 || w_g1) begin
                    r_a <= w_g1 ? req1_a : req0_a;
                    r_b <= w_g1 ? req1_b : req0_b;
                    r_op <= w_g1 ? req1_op : req0_op;
                    r_id <= w_g1;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp_result <= w_alu;
                    r_rsp_id <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_ptr <= ~r_rsp_id;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed checks of grant order, ALU results, backpressure and reset
module tb_alu_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic       rsp_valid, rsp_id, busy;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_result;
    int         tests = 0;
    int         fails = 0;

    alu_rr_arbiter #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    // Inputs already driven; checks grant, accept, execute, leaves DUT in RESP
    task automatic issue(input string tag, input logic exp_id, input logic [3:0] exp_res);
        #1;
        chk({tag, "_rdy0"}, {7'd0, req0_ready}, {7'd0, !exp_id});
        chk({tag, "_rdy1"}, {7'd0, req1_ready}, {7'd0, exp_id});
        tick();
        chk({tag, "_exec_busy"}, {6'd0, busy, rsp_valid}, 8'h02);
        tick();
        chk({tag, "_vld"}, {7'd0, rsp_valid}, 8'h01);
        chk({tag, "_id"}, {7'd0, rsp_id}, {7'd0, exp_id});
        chk({tag, "_res"}, {4'd0, rsp_result}, {4'd0, exp_res});
    endtask

    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_idle"}, {6'd0, busy, rsp_valid}, 8'h00);
    endtask

    initial begin
        #2;
        chk("rst_outs", {4'd0, busy, rsp_valid, req0_ready, req1_ready}, 8'h00);
        chk("rst_res", {3'd0, rsp_id, rsp_result}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_noreq", {6'd0, busy, req0_ready}, 8'h00);

        set0(1, 4'h5, 4'h3, 2'b00); issue("add53", 0, 4'h8); set0(0, 0, 0, 0); drain("add53");
        set0(1, 4'h3, 4'h5, 2'b10); issue("sub35", 0, 4'hE); set0(0, 0, 0, 0); drain("sub35");
        set0(1, 4'hF, 4'h1, 2'b00); issue("addF1", 0, 4'h0); set0(0, 0, 0, 0); drain("addF1");

        set1(1, 4'hC, 4'hA, 2'b00); issue("r1_add", 1, 4'h6); drain("r1_add");
        set1(1, 4'hC, 4'hA, 2'b01); issue("r1_or", 1, 4'hE); drain("r1_or");
        set1(1, 4'hC, 4'hA, 2'b10); issue("r1_sub", 1, 4'h2); drain("r1_sub");
        set1(1, 4'hC, 4'hA, 2'b11); issue("r1_xor", 1, 4'h6); drain("r1_xor");

        set0(1, 4'h1, 4'h2, 2'b00);
        set1(1, 4'h7, 4'h1, 2'b10);
        issue("cont0", 0, 4'h3); drain("cont0");
        issue("cont1", 1, 4'h6); drain("cont1");
        issue("cont2", 0, 4'h3); drain("cont2");
        issue("cont3", 1, 4'h6); drain("cont3");

        rsp_ready = 1'b0;
        set0(1, 4'h9, 4'h6, 2'b11);
        issue("bp", 0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {2'd0, busy, rsp_valid, rsp_id, req0_ready, req1_ready, 1'b0}, 8'h30);
            chk("bp_res", {4'd0, rsp_result}, 8'h0F);
        end
        drain("bp");

        set0(0, 0, 0, 0);
        set1(1, 4'h2, 4'h2, 2'b01);
        rsp_ready = 1'b0;
        issue("pre_rst", 1, 4'h2);
        set0(1, 4'h4, 4'h4, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {5'd0, busy, rsp_valid, rsp_id}, 8'h00);
        chk("rst_rdy", {6'd0, req0_ready, req1_ready}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        issue("post_rst", 0, 4'h0); drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
